// File: rtl/flat_vector_bridge.sv
// rtl/flat_vector_bridge.sv - byte-stream to flat-vector bridge for flattened fuzz wrappers
module flat_vector_bridge #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [IN_W-1:0]   in_flat,
    input  logic [OUT_W-1:0]  out_flat,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       vec_count
);

    localparam int IN_BYTES  = (IN_W + 7) / 8;
    localparam int OUT_BYTES = (OUT_W + 7) / 8;
    localparam int IDX_W     = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
    localparam int SND_W     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(IN_BYTES - 1);
    localparam logic [SND_W-1:0] LAST_SND   = SND_W'(OUT_BYTES - 1);
    localparam logic [7:0]       SETTLE_CNT = 8'(SETTLE);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [SND_W-1:0]       snd_idx;
    logic [7:0]             settle_cnt;
    logic [IN_W-1:0]        staging;
    logic [IN_W-1:0]        stage_next;
    logic [OUT_BYTES*8-1:0] resp_sr;
    logic [OUT_BYTES*8-1:0] resp_shift;
    logic [OUT_BYTES*8-1:0] out_ext;
    logic                   accept;
    logic                   handshake;

    assign s_ready   = (state == ST_LOAD);
    assign busy      = (state != ST_LOAD) || (idx != '0);
    assign accept    = s_valid && s_ready;
    assign handshake = m_valid && m_ready;

    // Bits of the top staging byte beyond IN_W are simply never stored.
    always_comb begin
        stage_next = staging;
        for (int i = 0; i < IN_W; i++) begin
            if (idx == IDX_W'(i / 8)) begin
                stage_next[i] = s_data[i % 8];
            end
        end
    end

    always_comb begin
        out_ext              = '0;
        out_ext[OUT_W-1:0]   = out_flat;
        resp_shift           = resp_sr >> 8;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            idx        <= '0;
            snd_idx    <= '0;
            settle_cnt <= '0;
            staging    <= '0;
            resp_sr    <= '0;
            in_flat    <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            vec_count  <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        staging <= stage_next;
                        if (idx == LAST_IDX) begin
                            in_flat    <= stage_next;
                            idx        <= '0;
                            settle_cnt <= SETTLE_CNT;
                            state      <= (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt == 8'd1) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    resp_sr <= out_ext;
                    m_data  <= out_ext[7:0];
                    m_valid <= 1'b1;
                    snd_idx <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (snd_idx == LAST_SND) begin
                            m_valid   <= 1'b0;
                            vec_count <= vec_count + 16'd1;
                            state     <= ST_LOAD;
                        end else begin
                            resp_sr <= resp_shift;
                            m_data  <= resp_shift[7:0];
                            snd_idx <= snd_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_flat_vector_bridge.sv
// tb/tb_flat_vector_bridge.sv - randomized self-checking bench for flat_vector_bridge
module tb_flat_vector_bridge;

    localparam int IN_W   = 12;
    localparam int OUT_W  = 10;
    localparam int SETTLE = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [IN_W-1:0]   in_flat;
    logic [OUT_W-1:0]  out_flat;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              busy;
    logic [15:0]       vec_count;

    logic [9:0]        perturb = '0;
    logic [15:0]       exp_count = '0;
    logic [IN_W-1:0]   prev_vec = '0;
    int                n_cmp = 0;
    int                n_bad = 0;

    // Stand-in wrapper: low 10 bits plus the top 2 bits, XOR an optional disturbance.
    assign out_flat = (in_flat[9:0] + {8'b0, in_flat[11:10]}) ^ perturb;

    flat_vector_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .in_flat  (in_flat),
        .out_flat (out_flat),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    function automatic logic [IN_W-1:0] model_vec(input logic [7:0] b0, input logic [7:0] b1);
        int v;
        v = (int'(b1) % 16) * 256 + int'(b0);
        return IN_W'(v);
    endfunction

    function automatic logic [15:0] model_resp(input logic [7:0] b0, input logic [7:0] b1);
        int v;
        int r;
        v = (int'(b1) % 16) * 256 + int'(b0);
        r = (v % 1024 + v / 1024) % 1024;
        return 16'(r);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic collect(input logic [15:0] exp_resp, input bit rand_ready, input bit chk_lat);
        int  lat = 0;
        int  n;
        bit  done;
        while (!m_valid && lat < 64) begin
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
        end
        if (chk_lat) begin
            n_cmp++;
            if (lat !== SETTLE + 1) begin
                n_bad++;
                $display("FAIL latency: got %0d cycles required %0d", lat, SETTLE + 1);
            end
        end
        perturb = 10'($urandom);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            done = 1'b0;
            while (!done && n < 200) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== exp_resp[k*8 +: 8]) begin
                    n_bad++;
                    $display("FAIL resp_byte%0d: m_valid=%b m_data=%h required 1/%h",
                             k, m_valid, m_data, exp_resp[k*8 +: 8]);
                end
                n_cmp++;
                if (s_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL s_ready_in_send: got %b required 0", s_ready);
                end
                m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                done = m_ready;
                @(negedge clk);
                n++;
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_timeout: byte %0d not handshaken", k);
            end
        end
        m_ready = 1'b0;
        perturb = '0;
        exp_count = exp_count + 16'd1;
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || vec_count !== exp_count) begin
            n_bad++;
            $display("FAIL post_send: m_valid=%b s_ready=%b vec_count=%h required 0/1/%h",
                     m_valid, s_ready, vec_count, exp_count);
        end
    endtask

    task automatic run_vector(input logic [7:0] b0, input logic [7:0] b1,
                              input bit rand_ready, input bit chk_lat);
        push_byte(b0);
        n_cmp++;
        if (in_flat !== prev_vec || busy !== 1'b1 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_byte0: in_flat=%h busy=%b s_ready=%b required %h/1/1",
                     in_flat, busy, s_ready, prev_vec);
        end
        push_byte(b1);
        n_cmp++;
        if (in_flat !== model_vec(b0, b1) || s_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL after_byte1: in_flat=%h s_ready=%b busy=%b required %h/0/1",
                     in_flat, s_ready, busy, model_vec(b0, b1));
        end
        collect(model_resp(b0, b1), rand_ready, chk_lat);
        prev_vec = model_vec(b0, b1);
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (in_flat !== '0 || m_valid !== 1'b0 || m_data !== 8'h00 || vec_count !== 16'h0000 ||
            busy !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: in_flat=%h m_valid=%b m_data=%h vec_count=%h busy=%b s_ready=%b required 0/0/00/0000/0/1",
                     tag, in_flat, m_valid, m_data, vec_count, busy, s_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset_state");
        rst_n = 1'b1;
        exp_count = '0;
        prev_vec = '0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_vector(8'h34, 8'h12, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_vector(8'($urandom), 8'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        logic [7:0]  d;
        int          n = 0;
        push_byte(8'hAB);
        push_byte(8'hCD);
        r = model_resp(8'hAB, 8'hCD);
        while (!m_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        d = m_data;
        s_data  = 8'h77;
        s_valid = 1'b1;
        n_cmp++;
        if (d !== r[7:0]) begin
            n_bad++;
            $display("FAIL bp_first_byte: m_data=%h required %h", d, r[7:0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== d || s_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: m_valid=%b m_data=%h s_ready=%b required 1/%h/0",
                         i, m_valid, m_data, s_ready, d);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== r[15:8]) begin
            n_bad++;
            $display("FAIL bp_second_byte: m_valid=%b m_data=%h required 1/%h", m_valid, m_data, r[15:8]);
        end
        @(negedge clk);
        m_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        n_cmp++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || vec_count !== exp_count) begin
            n_bad++;
            $display("FAIL bp_no_overlap: s_ready=%b busy=%b m_valid=%b vec_count=%h required 1/0/0/%h",
                     s_ready, busy, m_valid, vec_count, exp_count);
        end
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_held_accept: busy=%b required 1", busy);
        end
        push_byte(8'h0E);
        n_cmp++;
        if (in_flat !== model_vec(8'h77, 8'h0E)) begin
            n_bad++;
            $display("FAIL bp_next_vec: in_flat=%h required %h", in_flat, model_vec(8'h77, 8'h0E));
        end
        collect(model_resp(8'h77, 8'h0E), 1'b0, 1'b1);
        prev_vec = model_vec(8'h77, 8'h0E);
    endtask

    task automatic test_wrap();
        force dut.vec_count = 16'hFFFF;
        @(negedge clk);
        release dut.vec_count;
        @(negedge clk);
        exp_count = 16'hFFFF;
        n_cmp++;
        if (vec_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_preload: vec_count=%h required ffff", vec_count);
        end
        run_vector(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        push_byte(8'h5A);
        push_byte(8'h03);
        while (!m_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("reset_in_send");
        rst_n = 1'b1;
        exp_count = '0;
        prev_vec = '0;
        @(negedge clk);
        push_byte(8'hC3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("reset_after_byte0");
        rst_n = 1'b1;
        @(negedge clk);
        run_vector(8'($urandom), 8'($urandom), 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flat_vector_bridge.md
# flat_vector_bridge

Sequential harness-side bridge for flattened fuzz wrappers. It assembles a byte stream of stimulus into the wrapper's `in_flat` vector, applies it atomically and waits a settle interval. It then samples the wrapper's `out_flat` vector and streams the sampled response back as bytes. It sits between the fuzz host link (byte valid/ready) and any `*_wrapper` module, driving the `in_flat` side and reading the `out_flat` side.

## Interface
- IN_W, 4, width of `in_flat` driven to the wrapper (1..64)
- OUT_W, 3, width of `out_flat` read from the wrapper (1..64)
- SETTLE, 1, extra cycles between applying `in_flat` and sampling `out_flat` (0..255)
- Derived: IN_BYTES = ceil(IN_W/8), OUT_BYTES = ceil(OUT_W/8)

- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- s_data  input  8  stimulus byte
- s_valid  input  1  stimulus byte valid
- s_ready  output  1  bridge accepts stimulus byte
- in_flat  output  IN_W  registered stimulus vector to wrapper
- out_flat  input  OUT_W  response vector from wrapper (combinational w.r.t. `in_flat`)
- m_data  output  8  response byte
- m_valid  output  1  response byte valid
- m_ready  input  1  host accepts response byte
- busy  output  1  vector transaction in progress
- vec_count  output  16  completed vectors, wraps 0xFFFF→0

## Operation
- States:
  - LOAD: collect stimulus bytes.
  - SETTLE: wait for the settle interval.
  - CAPTURE: sample `out_flat`.
  - SEND: stream the response bytes.
- Reset values, while rst_n=0 at an edge:
  - State goes to LOAD, and the byte index clears to 0.
  - in_flat=0, m_valid=0, m_data=0, vec_count=0, busy=0.
  - The settle counter and the shift registers clear to 0.
- LOAD:
  - s_ready=1 and m_valid=0.
  - Each beat with s_valid&s_ready writes s_data into staging byte `idx`. The first byte is the least-significant byte.
  - Staging bits at IN_W and above are discarded.
  - `in_flat` does not change during LOAD.
  - When the beat with idx=IN_BYTES-1 is accepted:
    - The full staging vector, including that byte, is copied to `in_flat` on the same edge.
    - idx clears and the settle counter loads SETTLE.
    - Next state is SETTLE, or CAPTURE if SETTLE=0.
- SETTLE: s_ready=0. The counter decrements each cycle, and the state moves to CAPTURE in the cycle after the counter reads 1.
- CAPTURE, one cycle:
  - `out_flat` is zero-extended to OUT_BYTES*8 and loaded into the response shift register.
  - m_data is loaded with the low byte, m_valid is set, and the next state is SEND.
- SEND:
  - m_data and m_valid stay stable while m_valid&!m_ready.
  - On each m_valid&m_ready the register shifts right by 8 and m_data takes the next byte.
  - After the OUT_BYTES-th handshake: m_valid=0, vec_count increments, and the state returns to LOAD.
- busy=1 in SETTLE, CAPTURE and SEND, and in LOAD when idx≠0. Otherwise busy=0.
- `in_flat` holds the last applied vector until the next vector completes or reset occurs.
- Reset mid-transaction, in any state: all the above reset values apply on that edge. A partial vector is dropped, a pending response is dropped, and no count is taken.

## Timing
- All outputs are registered except s_ready and busy, which are decoded from registered state and idx only. They have no combinational path from any input.
- Latency, with edge T0 accepting the last stimulus byte:
  - `in_flat` is new after T0.
  - `out_flat` is sampled at edge T0+SETTLE+1.
  - m_valid is high from T0+SETTLE+1.
- Throughput with no backpressure: IN_BYTES + SETTLE + 1 + OUT_BYTES cycles per vector.
- s_ready=0 from T0 until the cycle after the last response handshake. Stimulus and response never overlap.
- s_valid asserted outside LOAD is ignored, and the byte must be held by the source.
- m_ready while m_valid=0 has no effect.
- When the final response handshake and a new s_valid are high in the same cycle, the new byte is not accepted in that cycle. It is accepted in the next cycle, in LOAD.

## Test plan
- Default parameters, `out_flat` = in_flat[3:2]+in_flat[1:0] (3-bit):
  - Send 0xFB. in_flat must read 4'hB after the accept edge.
  - m_valid must rise 2 cycles after the accept, with m_data=0x05.
  - vec_count must read 1 after the handshake.
- IN_W=12, OUT_W=10, loopback `out_flat`=in_flat[9:0]:
  - Send 0x34 then 0x12. in_flat must stay 0 after the first byte and become 12'h234 after the second.
  - The response must be 0x34 then 0x02.
- SETTLE=3, default widths:
  - Send 0x05.
  - m_valid must rise exactly 4 cycles after the accept edge.
  - Changing `out_flat` after the sample edge must not alter m_data.
- Backpressure:
  - Hold m_ready=0 for 5 cycles in SEND. m_data and m_valid must stay stable and s_ready must stay 0 throughout.
  - A held s_valid byte must be accepted only in the cycle after the response handshake.
- Reset mid-operation:
  - Assert rst_n=0 for 1 cycle during SEND, and separately after byte 1 of 2 (IN_W=12).
  - All outputs must take their reset values. The next full vector must be processed correctly, and vec_count must restart from 0.
- Wrap: preload by running 65536 vectors (or force). vec_count must go 0xFFFF→0x0000 on the next completion.
